// File: rtl/vend_pkg.sv
// Shared types for the vending dispense scheduler: FSM states, result codes, default widths.
// Pure declarations; no logic, latency or flow control here.
package vend_pkg;

   localparam int NUM_SLOTS_DEF     = 4;
   localparam int SLOT_W_DEF        = 2;
   localparam int STOCK_W_DEF       = 4;
   localparam int PRICE_W_DEF       = 8;
   localparam int MOTOR_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {IDLE, CHECK, MOTOR, JAM} state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SOLDOUT = 2'd1,
      ST_NOFUNDS = 2'd2,
      ST_JAM     = 2'd3
   } status_t;

endpackage

// File: rtl/vend_dispense_scheduler_if.sv
// Keypad/coin/motor/table-maintenance bundle of the dispense scheduler.
// Wires only; the slave side is the scheduler, the master side is the surrounding machine.
interface vend_dispense_scheduler_if
   import vend_pkg::*;
#(
   parameter int NUM_SLOTS = NUM_SLOTS_DEF,
   parameter int SLOT_W    = SLOT_W_DEF,
   parameter int STOCK_W   = STOCK_W_DEF,
   parameter int PRICE_W   = PRICE_W_DEF
) ();

   logic                 sel_valid;
   logic [SLOT_W-1:0]    sel_slot;
   logic                 sel_ready;
   logic [PRICE_W-1:0]   credit;
   logic                 restock_valid;
   logic [SLOT_W-1:0]    restock_slot;
   logic [STOCK_W-1:0]   restock_qty;
   logic                 price_wr_en;
   logic [SLOT_W-1:0]    price_wr_slot;
   logic [PRICE_W-1:0]   price_wr_data;
   logic                 motor_req;
   logic [SLOT_W-1:0]    motor_slot;
   logic                 motor_done;
   logic                 charge_valid;
   logic [PRICE_W-1:0]   charge_amount;
   logic                 status_valid;
   logic [1:0]           status;
   logic                 jammed;
   logic [NUM_SLOTS-1:0] stock_empty;

   modport master (
      output sel_valid, sel_slot, credit, restock_valid, restock_slot, restock_qty,
             price_wr_en, price_wr_slot, price_wr_data, motor_done,
      input  sel_ready, motor_req, motor_slot, charge_valid, charge_amount,
             status_valid, status, jammed, stock_empty
   );

   modport slave (
      input  sel_valid, sel_slot, credit, restock_valid, restock_slot, restock_qty,
             price_wr_en, price_wr_slot, price_wr_data, motor_done,
      output sel_ready, motor_req, motor_slot, charge_valid, charge_amount,
             status_valid, status, jammed, stock_empty
   );

endinterface

// File: rtl/vend_slot_table.sv
// Per-slot stock (saturating restock, decrement) and price tables; updates land next cycle,
// stock_empty one cycle after that. Never stalls: restock, decrement and price write always accepted.
module vend_slot_table #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2,
   parameter int STOCK_W   = 4,
   parameter int PRICE_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 restock_valid,
   input  logic [SLOT_W-1:0]    restock_slot,
   input  logic [STOCK_W-1:0]   restock_qty,
   input  logic                 dec_en,
   input  logic [SLOT_W-1:0]    dec_slot,
   input  logic                 price_wr_en,
   input  logic [SLOT_W-1:0]    price_wr_slot,
   input  logic [PRICE_W-1:0]   price_wr_data,
   input  logic [SLOT_W-1:0]    rd_slot,
   output logic [STOCK_W-1:0]   rd_stock,
   output logic [PRICE_W-1:0]   rd_price,
   output logic [NUM_SLOTS-1:0] stock_empty
);

   logic [STOCK_W-1:0] stock     [NUM_SLOTS];
   logic [STOCK_W-1:0] stock_nxt [NUM_SLOTS];
   logic [PRICE_W-1:0] price     [NUM_SLOTS];

   function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                  input logic [STOCK_W-1:0] b);
      logic [STOCK_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
   endfunction

   // Restock saturates first, then a same-slot vend takes one off the saturated value.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         stock_nxt[i] = stock[i];
         if (restock_valid && restock_slot == SLOT_W'(i))
            stock_nxt[i] = sat_add(stock_nxt[i], restock_qty);
         if (dec_en && dec_slot == SLOT_W'(i) && stock_nxt[i] != '0)
            stock_nxt[i] = stock_nxt[i] - STOCK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            stock[i] <= '0;
            price[i] <= '0;
         end
         stock_empty <= '1;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            stock[i]       <= stock_nxt[i];
            stock_empty[i] <= (stock[i] == '0);
         end
         if (price_wr_en)
            price[price_wr_slot] <= price_wr_data;
      end
   end

   assign rd_stock = stock[rd_slot];
   assign rd_price = price[rd_slot];

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Selection -> stock/credit check -> motor handshake -> charge pulse; result 2 cycles after accept for rejects,
// 1 cycle after motor_done for vends. sel_ready is high only in IDLE (one selection in flight); JAM holds it low until rst.
module vend_dispense_scheduler
   import vend_pkg::*;
#(
   parameter int NUM_SLOTS     = NUM_SLOTS_DEF,
   parameter int SLOT_W        = SLOT_W_DEF,
   parameter int STOCK_W       = STOCK_W_DEF,
   parameter int PRICE_W       = PRICE_W_DEF,
   parameter int MOTOR_TIMEOUT = MOTOR_TIMEOUT_DEF
) (
   input logic                      clk,
   input logic                      rst,
   vend_dispense_scheduler_if.slave bus
);

   localparam int            TW       = $clog2(MOTOR_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(MOTOR_TIMEOUT - 1);

   state_t             state, state_nxt;
   logic [SLOT_W-1:0]  cur_slot;
   logic [TW-1:0]      timer;
   logic [STOCK_W-1:0] rd_stock;
   logic [PRICE_W-1:0] rd_price;
   logic               accept, vend_done, status_pulse;
   status_t            status_code;

   logic               sel_ready_q, motor_req_q, charge_valid_q, status_valid_q, jammed_q;
   logic [SLOT_W-1:0]  motor_slot_q;
   logic [PRICE_W-1:0] charge_amount_q;
   status_t            status_q;

   assign accept    = (state == IDLE) && bus.sel_valid;
   assign vend_done = (state == MOTOR) && bus.motor_done;

   // Price writes are gated to IDLE so the price seen in CHECK is the one charged.
   vend_slot_table #(
      .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .STOCK_W(STOCK_W), .PRICE_W(PRICE_W)
   ) u_table (
      .clk           (clk),
      .rst           (rst),
      .restock_valid (bus.restock_valid),
      .restock_slot  (bus.restock_slot),
      .restock_qty   (bus.restock_qty),
      .dec_en        (vend_done),
      .dec_slot      (cur_slot),
      .price_wr_en   (bus.price_wr_en && (state == IDLE)),
      .price_wr_slot (bus.price_wr_slot),
      .price_wr_data (bus.price_wr_data),
      .rd_slot       (cur_slot),
      .rd_stock      (rd_stock),
      .rd_price      (rd_price),
      .stock_empty   (bus.stock_empty)
   );

   always_comb begin
      state_nxt    = state;
      status_pulse = 1'b0;
      status_code  = ST_OK;
      case (state)
         IDLE: if (accept) state_nxt = CHECK;
         CHECK: begin
            if (rd_stock == '0) begin
               status_pulse = 1'b1;
               status_code  = ST_SOLDOUT;
               state_nxt    = IDLE;
            end else if (bus.credit < rd_price) begin
               status_pulse = 1'b1;
               status_code  = ST_NOFUNDS;
               state_nxt    = IDLE;
            end else begin
               state_nxt = MOTOR;
            end
         end
         MOTOR: begin
            if (bus.motor_done) begin
               status_pulse = 1'b1;
               status_code  = ST_OK;
               state_nxt    = IDLE;
            end else if (timer == TMO_LAST) begin
               status_pulse = 1'b1;
               status_code  = ST_JAM;
               state_nxt    = JAM;
            end
         end
         JAM:     state_nxt = JAM;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cur_slot        <= '0;
         timer           <= '0;
         sel_ready_q     <= 1'b1;
         motor_req_q     <= 1'b0;
         motor_slot_q    <= '0;
         charge_valid_q  <= 1'b0;
         charge_amount_q <= '0;
         status_valid_q  <= 1'b0;
         status_q        <= ST_OK;
         jammed_q        <= 1'b0;
      end else begin
         state          <= state_nxt;
         timer          <= (state == MOTOR) ? timer + TW'(1) : '0;
         sel_ready_q    <= (state_nxt == IDLE);
         motor_req_q    <= (state_nxt == MOTOR);
         charge_valid_q <= vend_done;
         status_valid_q <= status_pulse;
         jammed_q       <= jammed_q || (state_nxt == JAM);
         if (accept)
            cur_slot <= bus.sel_slot;
         if (state == CHECK)
            motor_slot_q <= cur_slot;
         if (state == CHECK && state_nxt == MOTOR)
            charge_amount_q <= rd_price;
         if (status_pulse)
            status_q <= status_code;
      end
   end

   assign bus.sel_ready     = sel_ready_q;
   assign bus.motor_req     = motor_req_q;
   assign bus.motor_slot    = motor_slot_q;
   assign bus.charge_valid  = charge_valid_q;
   assign bus.charge_amount = charge_amount_q;
   assign bus.status_valid  = status_valid_q;
   assign bus.status        = status_q;
   assign bus.jammed        = jammed_q;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Directed bench for vend_dispense_scheduler: stock/price model predicts each result into a queue,
// which is popped when the DUT pulses status_valid.
module tb_vend_dispense_scheduler;
   import vend_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vend_dispense_scheduler_if vif ();

   vend_dispense_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (vif.slave)
   );

   typedef struct {
      logic [1:0] st;
      logic       cv;
      logic [7:0] amt;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   m_stock[4];
   int   m_price[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic idle_inputs();
      vif.sel_valid     = 1'b0;
      vif.sel_slot      = '0;
      vif.credit        = '0;
      vif.restock_valid = 1'b0;
      vif.restock_slot  = '0;
      vif.restock_qty   = '0;
      vif.price_wr_en   = 1'b0;
      vif.price_wr_slot = '0;
      vif.price_wr_data = '0;
      vif.motor_done    = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_stock[i] = 0;
         m_price[i] = 0;
      end
   endtask

   function automatic int sat(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic check_reset(input string p);
      chk({p, "_sel_ready"},     32'(vif.sel_ready),     1);
      chk({p, "_motor_req"},     32'(vif.motor_req),     0);
      chk({p, "_motor_slot"},    32'(vif.motor_slot),    0);
      chk({p, "_charge_valid"},  32'(vif.charge_valid),  0);
      chk({p, "_charge_amount"}, 32'(vif.charge_amount), 0);
      chk({p, "_status_valid"},  32'(vif.status_valid),  0);
      chk({p, "_status"},        32'(vif.status),        0);
      chk({p, "_jammed"},        32'(vif.jammed),        0);
      chk({p, "_stock_empty"},   32'(vif.stock_empty),   32'hF);
   endtask

   task automatic restock(input int slot, input int qty);
      @(negedge clk);
      vif.restock_valid = 1'b1;
      vif.restock_slot  = 2'(slot);
      vif.restock_qty   = 4'(qty);
      @(negedge clk);
      vif.restock_valid = 1'b0;
      m_stock[slot] = sat(m_stock[slot] + qty);
   endtask

   task automatic price_wr(input int slot, input int data);
      @(negedge clk);
      vif.price_wr_en   = 1'b1;
      vif.price_wr_slot = 2'(slot);
      vif.price_wr_data = 8'(data);
      @(negedge clk);
      vif.price_wr_en = 1'b0;
      m_price[slot] = data;
   endtask

   // dly: MOTOR cycle index (0 = first) on which motor_done pulses, negative = never.
   // rs_*: restock driven on the motor_done cycle. pw_*: price write driven on the first MOTOR cycle.
   task automatic vend(input int slot, input int cred, input int dly,
                       input int rs_slot = -1, input int rs_qty = 0,
                       input int pw_slot = -1, input int pw_data = 0);
      exp_t e, o;
      logic got, seen_mreq, mreq_at, rdy_at;
      o = '{2'd0, 1'b0, 8'd0, 0};
      got = 1'b0; seen_mreq = 1'b0; mreq_at = 1'b0; rdy_at = 1'b0;

      if (m_stock[slot] == 0)        e = '{ST_SOLDOUT, 1'b0, 8'd0, 1};
      else if (cred < m_price[slot]) e = '{ST_NOFUNDS, 1'b0, 8'd0, 1};
      else if (dly < 0)              e = '{ST_JAM, 1'b0, 8'd0, MOTOR_TIMEOUT_DEF + 1};
      else                           e = '{ST_OK, 1'b1, 8'(m_price[slot]), dly + 2};
      if (e.st == ST_OK) begin
         if (rs_slot >= 0) m_stock[rs_slot] = sat(m_stock[rs_slot] + rs_qty);
         m_stock[slot] = m_stock[slot] - 1;
      end
      exp_q.push_back(e);

      @(negedge clk);
      chk("sel_ready_idle", 32'(vif.sel_ready), 1);
      vif.sel_valid = 1'b1;
      vif.sel_slot  = 2'(slot);
      vif.credit    = 8'(cred);
      @(negedge clk);
      vif.sel_valid = 1'b0;
      chk("sel_ready_check", 32'(vif.sel_ready), 0);

      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         vif.motor_done    = 1'b0;
         vif.restock_valid = 1'b0;
         vif.price_wr_en   = 1'b0;
         if (vif.status_valid) begin
            got     = 1'b1;
            o.st    = vif.status;
            o.cv    = vif.charge_valid;
            o.amt   = vif.charge_amount;
            o.lat   = i;
            mreq_at = vif.motor_req;
            rdy_at  = vif.sel_ready;
         end else begin
            vif.credit = '0;
            if (vif.motor_req) begin
               seen_mreq = 1'b1;
               chk("motor_slot", 32'(vif.motor_slot), 32'(slot));
               if (i - 1 == dly) begin
                  vif.motor_done = 1'b1;
                  if (rs_slot >= 0) begin
                     vif.restock_valid = 1'b1;
                     vif.restock_slot  = 2'(rs_slot);
                     vif.restock_qty   = 4'(rs_qty);
                  end
               end
               if (i == 1 && pw_slot >= 0) begin
                  vif.price_wr_en   = 1'b1;
                  vif.price_wr_slot = 2'(pw_slot);
                  vif.price_wr_data = 8'(pw_data);
               end
            end
         end
      end

      e = exp_q.pop_front();
      if (!got) begin
         chk("status_timeout", 0, 1);
      end else begin
         chk("status", 32'(o.st), 32'(e.st));
         chk("charge_valid", 32'(o.cv), 32'(e.cv));
         if (e.cv) chk("charge_amount", 32'(o.amt), 32'(e.amt));
         chk("latency", o.lat, e.lat);
         chk("motor_req_seen", 32'(seen_mreq), 32'(e.st == ST_OK || e.st == ST_JAM));
         chk("motor_req_at_status", 32'(mreq_at), 0);
         chk("sel_ready_at_status", 32'(rdy_at), 32'(e.st != ST_JAM));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_clear();
      repeat (3) @(negedge clk);
      check_reset("rst0");
      rst = 1'b0;

      // basic vend, then drain slot 1 to prove stock went 3 -> 2 -> 0
      restock(1, 3);
      price_wr(1, 25);
      repeat (2) @(negedge clk);
      chk("empty_after_restock", 32'(vif.stock_empty), 32'hD);
      vend(1, 30, 5);
      vend(1, 30, 0);
      vend(1, 30, 0);
      vend(1, 30, 0);
      repeat (2) @(negedge clk);
      chk("empty_after_drain", 32'(vif.stock_empty), 32'hF);

      // motor_done outside MOTOR does nothing
      @(negedge clk);
      vif.motor_done = 1'b1;
      @(negedge clk);
      vif.motor_done = 1'b0;
      chk("done_idle_charge", 32'(vif.charge_valid), 0);
      chk("done_idle_status", 32'(vif.status_valid), 0);

      vend(2, 99, 3);

      price_wr(0, 50);
      restock(0, 1);
      vend(0, 49, 2);
      vend(0, 50, 2);

      // saturation, then same-slot restock on the done cycle
      restock(3, 15);
      restock(3, 4);
      vend(3, 0, 1, 3, 2);
      for (int k = 0; k < 15; k++) vend(3, 0, 0);

      // price write in MOTOR is dropped, in IDLE it lands
      price_wr(2, 10);
      restock(2, 3);
      vend(2, 10, 3, -1, 0, 2, 40);
      vend(2, 10, 1);
      price_wr(2, 40);
      vend(2, 10, 1);
      vend(2, 40, 0);

      // reset in the middle of a vend
      restock(1, 1);
      price_wr(1, 5);
      @(negedge clk);
      vif.sel_valid = 1'b1;
      vif.sel_slot  = 2'd1;
      vif.credit    = 8'd5;
      @(negedge clk);
      vif.sel_valid = 1'b0;
      @(negedge clk);
      chk("abort_motor_req_before", 32'(vif.motor_req), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_motor_req", 32'(vif.motor_req), 0);
      chk("abort_charge", 32'(vif.charge_valid), 0);
      chk("abort_status", 32'(vif.status_valid), 0);
      rst = 1'b0;
      model_clear();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_charge_after", 32'(vif.charge_valid), 0);
      end
      chk("abort_stock_empty", 32'(vif.stock_empty), 32'hF);
      chk("abort_sel_ready", 32'(vif.sel_ready), 1);

      // jam: no motor_done at all
      restock(0, 1);
      vend(0, 0, -1);
      chk("jammed_flag", 32'(vif.jammed), 1);
      chk("jam_sel_ready", 32'(vif.sel_ready), 0);
      @(negedge clk);
      vif.sel_valid = 1'b1;
      vif.sel_slot  = 2'd0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("jam_stall_ready", 32'(vif.sel_ready), 0);
         chk("jam_stall_motor", 32'(vif.motor_req), 0);
         chk("jam_stall_status", 32'(vif.status_valid), 0);
      end
      vif.sel_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset("rst1");
      rst = 1'b0;
      model_clear();

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
